// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: opcodes, ALU encodings,
// the pipelined control bundle and the operand-forwarding helper.
package cpu_pkg;

    localparam int unsigned RegW = 3;

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpAndi  = 4'b0001;
    localparam logic [3:0] OpAddi  = 4'b0010;
    localparam logic [3:0] OpLw    = 4'b0011;
    localparam logic [3:0] OpSw    = 4'b0100;
    localparam logic [3:0] OpBeq   = 4'b0101;
    localparam logic [3:0] OpBne   = 4'b0110;
    localparam logic [3:0] OpFor   = 4'b0111;
    localparam logic [3:0] OpJmp   = 4'b1000;
    localparam logic [3:0] OpCall  = 4'b1001;
    localparam logic [3:0] OpRet   = 4'b1010;

    localparam logic [2:0] FuncAnd = 3'b000;
    localparam logic [2:0] FuncAdd = 3'b001;
    localparam logic [2:0] FuncSub = 3'b010;
    localparam logic [2:0] FuncSll = 3'b011;
    localparam logic [2:0] FuncSrl = 3'b100;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluAdd = 3'b001;
    localparam logic [2:0] AluSub = 3'b010;
    localparam logic [2:0] AluSll = 3'b011;
    localparam logic [2:0] AluSrl = 3'b100;

    localparam logic [15:0] NopInstr = 16'hFFFF;

    // Control bits that travel down the pipeline past ID
    typedef struct packed {
        logic       for_signal;
        logic       branch;
        logic       bne;
        logic       load;
        logic       write_to_mem;
        logic       write_to_reg;
        logic       imm;
        logic       logical;
        logic [2:0] alu_control;
    } ctrl_t;

    // EX/MEM beats MEM/WB beats the ID/EX copy; R0 is never forwarded.
    function automatic logic [15:0] forward(
        input logic [RegW-1:0] idx,
        input logic [15:0]     reg_val,
        input logic            mem_hit,
        input logic [RegW-1:0] mem_rd,
        input logic [15:0]     mem_val,
        input logic            wb_hit,
        input logic [RegW-1:0] wb_rd,
        input logic [15:0]     wb_val
    );
        if (idx == '0)                       return reg_val;
        else if (mem_hit && mem_rd == idx)   return mem_val;
        else if (wb_hit && wb_rd == idx)     return wb_val;
        else                                 return reg_val;
    endfunction

endpackage

// File: rtl/controller.sv
// Main decoder: combinational control signals from opcode and func.
// Every output is 0 for NOPs and for unused R-type func codes.
module controller
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [2:0] func,
    output logic       for_signal,
    output logic       update_rr,
    output logic       jmp,
    output logic       select_pc_src,
    output logic       load,
    output logic       rtype,
    output logic       logical,
    output logic       write_to_reg,
    output logic       imm,
    output logic       bne,
    output logic       branch,
    output logic       write_to_mem,
    output logic [2:0] alu_control
);

    always_comb begin
        for_signal    = 1'b0;
        update_rr     = 1'b0;
        jmp           = 1'b0;
        select_pc_src = 1'b0;
        load          = 1'b0;
        rtype         = 1'b0;
        logical       = 1'b0;
        write_to_reg  = 1'b0;
        imm           = 1'b0;
        bne           = 1'b0;
        branch        = 1'b0;
        write_to_mem  = 1'b0;
        alu_control   = AluAnd;
        case (op)
            OpRtype: begin
                if (func <= FuncSrl) begin
                    rtype        = 1'b1;
                    write_to_reg = 1'b1;
                    alu_control  = func;
                end
            end
            OpAndi: begin
                logical      = 1'b1;
                imm          = 1'b1;
                write_to_reg = 1'b1;
                alu_control  = AluAnd;
            end
            OpAddi: begin
                imm          = 1'b1;
                write_to_reg = 1'b1;
                alu_control  = AluAdd;
            end
            OpLw: begin
                imm          = 1'b1;
                load         = 1'b1;
                write_to_reg = 1'b1;
                alu_control  = AluAdd;
            end
            OpSw: begin
                imm          = 1'b1;
                write_to_mem = 1'b1;
                alu_control  = AluAdd;
            end
            OpBeq: begin
                branch      = 1'b1;
                alu_control = AluSub;
            end
            OpBne: begin
                branch      = 1'b1;
                bne         = 1'b1;
                alu_control = AluSub;
            end
            OpFor: begin
                for_signal   = 1'b1;
                write_to_reg = 1'b1;
                alu_control  = AluSub;
            end
            OpJmp: jmp = 1'b1;
            OpCall: begin
                jmp       = 1'b1;
                update_rr = 1'b1;
            end
            OpRet: select_pc_src = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Five-stage IF/ID/EX/MEM/WB datapath with forwarding, load-use stall,
// ID-resolved jumps (JMP/CALL/RET) and EX-resolved branches (BEQ/BNE/FOR).
module data_path
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 16,
    parameter int unsigned NREGS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] read_data,
    output logic            mem_write,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] write_data
);

    logic [XLEN-1:0] pc_q, pc_d, rr_q, rr_d;
    logic [XLEN-1:0] rf_q [NREGS];

    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;

    ctrl_t           idex_ctrl_q, idex_ctrl_d;
    logic [XLEN-1:0] idex_ra_q, idex_rb_q, idex_rc_q, idex_pc_q;
    logic [XLEN-1:0] idex_ra_d, idex_rb_d, idex_rc_d, idex_pc_d;
    logic [RegW-1:0] idex_a_q, idex_b_q, idex_c_q, idex_a_d, idex_b_d, idex_c_d;
    logic [5:0]      idex_imm6_q, idex_imm6_d;

    logic            exmem_wr_q, exmem_load_q, exmem_mw_q;
    logic [RegW-1:0] exmem_rd_q;
    logic [XLEN-1:0] exmem_alu_q, exmem_wdata_q;

    logic            memwb_wr_q;
    logic [RegW-1:0] memwb_rd_q;
    logic [XLEN-1:0] memwb_data_q;

    // ---------------- ID ----------------
    logic [3:0]      id_op;
    logic [RegW-1:0] id_a, id_b, id_c;
    logic            id_for, id_update_rr, id_jmp, id_sel_pc, id_load, id_rtype, id_logical;
    logic            id_wr, id_imm, id_bne, id_branch, id_mw;
    logic [2:0]      id_alu;
    logic [XLEN-1:0] id_ra, id_rb, id_rc, id_jump_target;
    logic            id_use_a, id_use_b, id_use_c, id_jump, load_use;

    assign id_op = ifid_instr_q[15:12];
    assign id_a  = ifid_instr_q[11:9];
    assign id_b  = ifid_instr_q[8:6];
    assign id_c  = ifid_instr_q[5:3];

    controller u_controller (
        .op            (id_op),
        .func          (ifid_instr_q[2:0]),
        .for_signal    (id_for),
        .update_rr     (id_update_rr),
        .jmp           (id_jmp),
        .select_pc_src (id_sel_pc),
        .load          (id_load),
        .rtype         (id_rtype),
        .logical       (id_logical),
        .write_to_reg  (id_wr),
        .imm           (id_imm),
        .bne           (id_bne),
        .branch        (id_branch),
        .write_to_mem  (id_mw),
        .alu_control   (id_alu)
    );

    // Register read with write-before-read bypass from WB
    always_comb begin
        id_ra = rf_q[id_a];
        id_rb = rf_q[id_b];
        id_rc = rf_q[id_c];
        if (memwb_wr_q && memwb_rd_q != '0) begin
            if (memwb_rd_q == id_a) id_ra = memwb_data_q;
            if (memwb_rd_q == id_b) id_rb = memwb_data_q;
            if (memwb_rd_q == id_c) id_rc = memwb_data_q;
        end
    end

    assign id_use_a = id_mw | id_branch | id_for;
    assign id_use_b = id_rtype | id_imm | id_branch | id_for;
    assign id_use_c = id_rtype;
    assign load_use = idex_ctrl_q.load && idex_a_q != '0 &&
                      ((id_use_a && id_a == idex_a_q) ||
                       (id_use_b && id_b == idex_a_q) ||
                       (id_use_c && id_c == idex_a_q));
    assign id_jump        = id_jmp | id_sel_pc;
    assign id_jump_target = id_sel_pc ? rr_q : {ifid_pc_q[15:12], ifid_instr_q[11:0]};

    // ---------------- EX ----------------
    logic [XLEN-1:0] ex_a, ex_b, ex_c, ex_imm, alu_a, alu_b, alu_res, ex_target;
    logic            exmem_fwd, ex_taken;

    assign exmem_fwd = exmem_wr_q && !exmem_load_q;
    assign ex_a = forward(idex_a_q, idex_ra_q, exmem_fwd, exmem_rd_q, exmem_alu_q,
                          memwb_wr_q, memwb_rd_q, memwb_data_q);
    assign ex_b = forward(idex_b_q, idex_rb_q, exmem_fwd, exmem_rd_q, exmem_alu_q,
                          memwb_wr_q, memwb_rd_q, memwb_data_q);
    assign ex_c = forward(idex_c_q, idex_rc_q, exmem_fwd, exmem_rd_q, exmem_alu_q,
                          memwb_wr_q, memwb_rd_q, memwb_data_q);

    assign ex_imm = idex_ctrl_q.logical ? {10'b0, idex_imm6_q} :
                                          {{10{idex_imm6_q[5]}}, idex_imm6_q};
    // FOR decrements Ra; everything else operates on Rb and Rc/imm
    assign alu_a = idex_ctrl_q.for_signal ? ex_a : ex_b;
    assign alu_b = idex_ctrl_q.for_signal ? 16'd1 : (idex_ctrl_q.imm ? ex_imm : ex_c);

    always_comb begin
        case (idex_ctrl_q.alu_control)
            AluAnd:  alu_res = alu_a & alu_b;
            AluAdd:  alu_res = alu_a + alu_b;
            AluSub:  alu_res = alu_a - alu_b;
            AluSll:  alu_res = alu_a << alu_b[3:0];
            AluSrl:  alu_res = alu_a >> alu_b[3:0];
            default: alu_res = '0;
        endcase
    end

    assign ex_taken = (idex_ctrl_q.branch && (idex_ctrl_q.bne ? (ex_a != ex_b) : (ex_a == ex_b)))
                   || (idex_ctrl_q.for_signal && alu_res != '0);
    assign ex_target = idex_ctrl_q.for_signal ? ex_b : idex_pc_q + ex_imm;

    // ---------------- hazard / redirect ----------------
    always_comb begin
        pc_d         = pc_q + 16'd1;
        rr_d         = rr_q;
        ifid_instr_d = instr;
        ifid_pc_d    = pc_q;
        idex_ctrl_d  = '{for_signal: id_for, branch: id_branch, bne: id_bne, load: id_load,
                         write_to_mem: id_mw, write_to_reg: id_wr, imm: id_imm,
                         logical: id_logical, alu_control: id_alu};
        idex_ra_d    = id_ra;
        idex_rb_d    = id_rb;
        idex_rc_d    = id_rc;
        idex_a_d     = id_a;
        idex_b_d     = id_b;
        idex_c_d     = id_c;
        idex_imm6_d  = ifid_instr_q[5:0];
        idex_pc_d    = ifid_pc_q;
        if (ex_taken || load_use) begin
            idex_ctrl_d = '0;
            idex_ra_d   = '0;
            idex_rb_d   = '0;
            idex_rc_d   = '0;
            idex_a_d    = '0;
            idex_b_d    = '0;
            idex_c_d    = '0;
            idex_imm6_d = '0;
            idex_pc_d   = '0;
        end
        if (ex_taken) begin
            pc_d         = ex_target;
            ifid_instr_d = NopInstr;
            ifid_pc_d    = '0;
        end else if (load_use) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
        end else if (id_jump) begin
            pc_d         = id_jump_target;
            ifid_instr_d = NopInstr;
            ifid_pc_d    = '0;
            if (id_update_rr) rr_d = ifid_pc_q + 16'd1;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= '0;
            rr_q          <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            ifid_instr_q  <= NopInstr;
            ifid_pc_q     <= '0;
            idex_ctrl_q   <= '0;
            idex_ra_q     <= '0;
            idex_rb_q     <= '0;
            idex_rc_q     <= '0;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_c_q      <= '0;
            idex_imm6_q   <= '0;
            idex_pc_q     <= '0;
            exmem_wr_q    <= 1'b0;
            exmem_load_q  <= 1'b0;
            exmem_mw_q    <= 1'b0;
            exmem_rd_q    <= '0;
            exmem_alu_q   <= '0;
            exmem_wdata_q <= '0;
            memwb_wr_q    <= 1'b0;
            memwb_rd_q    <= '0;
            memwb_data_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            rr_q          <= rr_d;
            if (memwb_wr_q && memwb_rd_q != '0) rf_q[memwb_rd_q] <= memwb_data_q;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            idex_ctrl_q   <= idex_ctrl_d;
            idex_ra_q     <= idex_ra_d;
            idex_rb_q     <= idex_rb_d;
            idex_rc_q     <= idex_rc_d;
            idex_a_q      <= idex_a_d;
            idex_b_q      <= idex_b_d;
            idex_c_q      <= idex_c_d;
            idex_imm6_q   <= idex_imm6_d;
            idex_pc_q     <= idex_pc_d;
            exmem_wr_q    <= idex_ctrl_q.write_to_reg;
            exmem_load_q  <= idex_ctrl_q.load;
            exmem_mw_q    <= idex_ctrl_q.write_to_mem;
            exmem_rd_q    <= idex_a_q;
            exmem_alu_q   <= alu_res;
            exmem_wdata_q <= ex_a;
            memwb_wr_q    <= exmem_wr_q;
            memwb_rd_q    <= exmem_rd_q;
            memwb_data_q  <= exmem_load_q ? read_data : exmem_alu_q;
        end
    end

    assign pc         = pc_q;
    assign mem_write  = exmem_mw_q;
    assign alu_out    = exmem_alu_q;
    assign write_data = exmem_wdata_q;

endmodule

// File: tb/tb_data_path.sv
// Directed program bench for data_path: pc trace, store stream, squash checks
// and asynchronous reset behaviour.
module tb_data_path;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr, pc, read_data, alu_out, write_data;
    logic        mem_write;

    logic [15:0] imem [64];
    logic [15:0] dmem [256];
    logic [31:0] stores [$];

    int n_checks = 0;
    int n_fail   = 0;

    data_path dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .pc         (pc),
        .read_data  (read_data),
        .mem_write  (mem_write),
        .alu_out    (alu_out),
        .write_data (write_data)
    );

    always #5 clk = ~clk;

    assign instr = imem[pc[5:0]];

    always @(negedge clk) begin
        read_data <= dmem[alu_out[7:0]];
        if (rst && mem_write) stores.push_back({alu_out, write_data});
    end
    always @(posedge clk) if (mem_write) dmem[alu_out[7:0]] <= write_data;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] a, b, c, f);
        return {4'b0000, a, b, c, f};
    endfunction
    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] a, b,
                                          input logic [5:0] imm6);
        return {op, a, b, imm6};
    endfunction
    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [11:0] imm12);
        return {op, imm12};
    endfunction

    // Expected pc for cycles 0..17 after reset release
    logic [15:0] exp_pc [18] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'h20, 16'h21,
                                  16'd5, 16'd6, 16'd7, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11,
                                  16'd12, 16'd13};
    logic [15:0] exp_addr [6] = '{16'd10, 16'd20, 16'd21, 16'd22, 16'd23, 16'd24};
    logic [15:0] exp_data [6] = '{16'd8,  16'd0,  16'd3,  16'd16, 16'd1,  16'd8};

    initial begin
        for (int i = 0; i < 64; i++)  imem[i] = 16'hFFFF;
        for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
        read_data = '0;
        imem[0]  = enc_i(4'b0010, 3'd1, 3'd0, 6'd5);        // ADDI R1,R0,5
        imem[1]  = enc_i(4'b0010, 3'd2, 3'd0, 6'd3);        // ADDI R2,R0,3
        imem[2]  = enc_r(3'd3, 3'd1, 3'd2, 3'b001);         // ADD R3,R1,R2
        imem[3]  = enc_i(4'b0100, 3'd3, 3'd0, 6'd10);       // SW R3,[R0+10]
        imem[4]  = enc_j(4'b1001, 12'h020);                 // CALL 0x020
        imem[5]  = enc_i(4'b0011, 3'd4, 3'd0, 6'd10);       // LW R4,[R0+10]
        imem[6]  = enc_r(3'd5, 3'd4, 3'd4, 3'b001);         // ADD R5,R4,R4
        imem[7]  = enc_i(4'b0110, 3'd1, 3'd2, 6'd3);        // BNE R1,R2,+3
        imem[8]  = enc_i(4'b0010, 3'd6, 3'd0, 6'd7);        // squashed
        imem[9]  = enc_i(4'b0100, 3'd1, 3'd0, 6'd11);       // squashed
        imem[10] = enc_i(4'b0101, 3'd1, 3'd2, 6'd3);        // BEQ not taken
        imem[11] = enc_i(4'b0010, 3'd7, 3'd0, 6'd1);        // ADDI R7,R0,1
        imem[12] = enc_i(4'b0010, 3'd1, 3'd0, 6'd3);        // ADDI R1,R0,3
        imem[13] = enc_i(4'b0010, 3'd2, 3'd0, 6'd14);       // ADDI R2,R0,14
        imem[14] = enc_i(4'b0010, 3'd6, 3'd6, 6'd1);        // body: R6++
        imem[15] = enc_i(4'b0111, 3'd1, 3'd2, 6'd0);        // FOR R1,R2
        imem[16] = enc_i(4'b0100, 3'd1, 3'd0, 6'd20);
        imem[17] = enc_i(4'b0100, 3'd6, 3'd0, 6'd21);
        imem[18] = enc_i(4'b0100, 3'd5, 3'd0, 6'd22);
        imem[19] = enc_i(4'b0100, 3'd7, 3'd0, 6'd23);
        imem[20] = enc_i(4'b0100, 3'd4, 3'd0, 6'd24);
        imem[21] = enc_j(4'b1000, 12'd21);                  // JMP self
        imem[32] = enc_j(4'b1010, 12'h000);                 // RET

        #2;
        check_eq("reset_pc", pc, 16'd0);
        check_eq("reset_mem_write", {15'd0, mem_write}, 16'd0);
        check_eq("reset_alu_out", alu_out, 16'd0);
        check_eq("reset_write_data", write_data, 16'd0);

        #10 rst = 1'b1;  // t=12, cycle 0
        check_eq("pc_c0", pc, exp_pc[0]);
        for (int k = 1; k < 18; k++) begin
            @(negedge clk);
            check_eq($sformatf("pc_c%0d", k), pc, exp_pc[k]);
        end

        repeat (100) @(negedge clk);
        check_eq("store_count", 16'(stores.size()), 16'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < stores.size()) begin
                check_eq($sformatf("store%0d_addr", i), stores[i][31:16], exp_addr[i]);
                check_eq($sformatf("store%0d_data", i), stores[i][15:0], exp_data[i]);
            end
        end
        check_eq("squashed_sw", dmem[11], 16'd0);
        check_eq("halt_pc", pc, 16'd21);

        // Restart and hit reset while the first SW is in MEM
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_mem_write", {15'd0, mem_write}, 16'd1);
        check_eq("pre_rst_alu_out", alu_out, 16'd10);
        check_eq("pre_rst_r1", dut.rf_q[1], 16'd5);
        #1 rst = 1'b0;
        #1;
        check_eq("async_rst_pc", pc, 16'd0);
        check_eq("async_rst_mem_write", {15'd0, mem_write}, 16'd0);
        check_eq("async_rst_alu_out", alu_out, 16'd0);
        check_eq("async_rst_write_data", write_data, 16'd0);
        for (int r = 1; r < 8; r++) check_eq($sformatf("async_rst_r%0d", r), dut.rf_q[r], 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
